// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter.
//
// Sends one byte to a PS/2 device. The host holds the clock low (inhibit), makes a
// request-to-send, then shifts out data[0..7], odd parity and the stop bit on each
// device-generated falling clock edge. Finally it samples the device ACK. A failed
// frame (timeout or no ACK) is re-sent automatically up to RETRIES times.
//
// Ports:
//   qzt_clk   system clock, all logic on its rising edge
//   reset     synchronous, active-high reset
//   data      byte to send, LSB first
//   send      start request, sampled only in IDLE
//   PS2C      PS/2 clock line, open-drain (driven 0 or z)
//   PS2D      PS/2 data line, open-drain (driven 0 or z)
//   busy      high whenever the state is not IDLE
//   done      1-cycle pulse when the frame is ACKed
//   err       1-cycle pulse on final failure, after retries are exhausted
//   err_code  00 none, 01 timeout, 10 no ACK; held until the next send is accepted
//   status    current state code, for LED debug
module ps2_host_tx #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_US = 15000,
   parameter int FILTER     = 8,
   parameter int RETRIES    = 2
) (
   input  logic       qzt_clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       send,
   inout  wire        PS2C,
   inout  wire        PS2D,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [3:0] status
);

   localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
   localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int IW = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [FW-1:0] F_LAST = FW'(FILTER - 1);
   localparam logic [RW-1:0] R_INIT = RW'(RETRIES);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      INHIBIT = 4'd1,
      REQ     = 4'd2,
      SHIFT   = 4'd3,
      ACK     = 4'd4,
      DONE    = 4'd5,
      FAIL    = 4'd6
   } state_t;

   state_t          state, state_n;
   logic [8:0]      frame, frame_n;      // {parity, data}
   logic [3:0]      bit_idx, bit_idx_n;
   logic [IW-1:0]   icnt, icnt_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic [RW-1:0]   retry_cnt, retry_cnt_n;
   logic [1:0]      code, code_n;
   logic [1:0]      err_kind;
   logic            c_low, d_low;

   logic            ps2c_p0, ps2c_p1, ps2d_p0, ps2d_p1;
   logic            ps2c_flt, fall;
   logic [FW-1:0]   fcnt;

   // Stage p0/p1: line synchronisers, then the PS2C stability filter.
   // A change on the synchronised clock is accepted only after FILTER consecutive
   // cycles at the new level; fall marks an accepted 1->0 change.
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         ps2c_p0  <= 1'b1;
         ps2c_p1  <= 1'b1;
         ps2d_p0  <= 1'b1;
         ps2d_p1  <= 1'b1;
         ps2c_flt <= 1'b1;
         fcnt     <= '0;
         fall     <= 1'b0;
      end else begin
         ps2c_p0 <= PS2C;
         ps2c_p1 <= ps2c_p0;
         ps2d_p0 <= PS2D;
         ps2d_p1 <= ps2d_p0;
         fall    <= 1'b0;
         if (ps2c_p1 == ps2c_flt) begin
            fcnt <= '0;
         end else if (fcnt == F_LAST) begin
            fcnt     <= '0;
            ps2c_flt <= ps2c_p1;
            fall     <= ~ps2c_p1;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

   // Transmit FSM state register.
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_idx   <= '0;
         icnt      <= '0;
         tcnt      <= '0;
         retry_cnt <= '0;
         code      <= 2'b00;
      end else begin
         state     <= state_n;
         bit_idx   <= bit_idx_n;
         icnt      <= icnt_n;
         tcnt      <= tcnt_n;
         retry_cnt <= retry_cnt_n;
         code      <= code_n;
      end
   end

   // The latched byte is pure data and needs no reset.
   always_ff @(posedge qzt_clk) begin
      frame <= frame_n;
   end

   always_comb begin
      state_n     = state;
      frame_n     = frame;
      bit_idx_n   = bit_idx;
      icnt_n      = icnt;
      tcnt_n      = tcnt;
      retry_cnt_n = retry_cnt;
      code_n      = code;
      err_kind    = 2'b00;
      c_low       = 1'b0;
      d_low       = 1'b0;

      case (state)
         IDLE: begin
            if (send) begin
               frame_n     = {~^data, data};
               retry_cnt_n = R_INIT;
               code_n      = 2'b00;
               icnt_n      = '0;
               state_n     = INHIBIT;
            end
         end
         INHIBIT: begin
            c_low = 1'b1;
            if (icnt == I_LAST) begin
               d_low   = 1'b1;
               tcnt_n  = '0;
               state_n = REQ;
            end else begin
               icnt_n = icnt + IW'(1);
            end
         end
         REQ, SHIFT, ACK: begin
            if (state == REQ)
               d_low = 1'b1;
            else if (state == SHIFT)
               d_low = ~frame[bit_idx];
            // Timeout has priority over a coincident falling edge.
            if (tcnt == T_LAST) begin
               err_kind = 2'b01;
            end else begin
               tcnt_n = tcnt + TW'(1);
               if (fall) begin
                  if (state == REQ) begin
                     bit_idx_n = '0;
                     state_n   = SHIFT;
                  end else if (state == SHIFT) begin
                     // After parity, the stop bit is the released line held in ACK.
                     if (bit_idx == 4'd8)
                        state_n = ACK;
                     else
                        bit_idx_n = bit_idx + 4'd1;
                  end else if (ps2d_p1) begin
                     err_kind = 2'b10;
                  end else begin
                     state_n = DONE;
                  end
               end
            end
            if (err_kind != 2'b00) begin
               if (retry_cnt != '0) begin
                  retry_cnt_n = retry_cnt - RW'(1);
                  icnt_n      = '0;
                  state_n     = INHIBIT;
               end else begin
                  code_n  = err_kind;
                  state_n = FAIL;
               end
            end
         end
         DONE, FAIL: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign PS2C     = c_low ? 1'b0 : 1'bz;
   assign PS2D     = d_low ? 1'b0 : 1'bz;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign err      = (state == FAIL);
   assign err_code = code;
   assign status   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed testbench for ps2_host_tx with a behavioural PS/2
// device model (clock generator, bit sampler, ACK driver, optional clock glitch).
module tb_ps2_host_tx;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       send;
   wire        ps2c;
   wire        ps2d;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic [3:0] status;
   logic       dev_clk_low, dev_dat_low;

   int n_checks = 0;
   int n_errors = 0;

   pullup (ps2c);
   pullup (ps2d);
   assign ps2c = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2d = dev_dat_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_HZ    (1_000_000),
      .INHIBIT_US(100),
      .TIMEOUT_US(200),
      .FILTER    (2),
      .RETRIES   (1)
   ) dut (
      .qzt_clk (clk),
      .reset   (rst),
      .data    (data),
      .send    (send),
      .PS2C    (ps2c),
      .PS2D    (ps2d),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .err_code(err_code),
      .status  (status)
   );

   // Pulse counters and phase-length monitors.
   int         done_cnt = 0, err_cnt = 0, inh_phases = 0;
   int         inh_run = 0, last_inh = 0, req_run = 0, last_req = 0;
   logic [3:0] prev_status = 4'd0;

   always @(negedge clk) begin
      prev_status <= status;
      if (done) done_cnt <= done_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
      if (status == 4'd1) begin
         inh_run <= inh_run + 1;
         if (prev_status != 4'd1) inh_phases <= inh_phases + 1;
      end else if (inh_run != 0) begin
         last_inh <= inh_run;
         inh_run  <= 0;
      end
      if (status == 4'd2) begin
         req_run <= req_run + 1;
      end else if (req_run != 0) begin
         last_req <= req_run;
         req_run  <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Device side of one frame: waits for inhibit and release, then generates
   // nclk clocks, sampling the data line just before each falling edge.
   task automatic dev_frame(input int nclk, input bit ack, input int glitch_at,
                            output logic [10:0] smp, output bit ok);
      int n;
      ok  = 1'b1;
      smp = '0;
      n   = 0;
      while (ps2c !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      if (ps2c !== 1'b0) begin ok = 1'b0; return; end
      n = 0;
      while (ps2c !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      if (ps2c !== 1'b1) begin ok = 1'b0; return; end
      repeat (8) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         smp = {ps2d, smp[10:1]};
         if (i == 10 && ack) begin
            dev_dat_low = 1'b1;
            repeat (2) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         dev_dat_low = 1'b0;
         if (i == glitch_at) begin
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF - 3) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   task automatic do_send(input logic [7:0] d);
      @(negedge clk);
      data = d;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < maxc) begin @(negedge clk); n++; end
      check({tag, "_idle"}, 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   // Full ACKed frame; par is the hand-computed odd-parity bit for d.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                            input int glitch_at);
      int d0, e0;
      logic [10:0] smp;
      bit ok;
      d0 = done_cnt;
      e0 = err_cnt;
      do_send(d);
      check({tag, "_c_low_lat"}, 32'(ps2c), 32'd0);
      check({tag, "_inh_status"}, 32'(status), 32'd1);
      dev_frame(11, 1'b1, glitch_at, smp, ok);
      check({tag, "_dev_ok"}, 32'(ok), 32'd1);
      check({tag, "_frame"}, 32'(smp), 32'({1'b1, par, d, 1'b0}));
      wait_idle(tag, 300);
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
      check({tag, "_code"}, 32'(err_code), 32'd0);
      check({tag, "_inh_len"}, 32'(last_inh), 32'd100);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, p0, n;
      logic [10:0] smp;
      bit ok;

      rst = 1'b1; send = 1'b0; data = 8'h00;
      dev_clk_low = 1'b0; dev_dat_low = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_status", 32'(status), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done_err", 32'({done, err}), 32'd0);
      check("rst_code", 32'(err_code), 32'd0);
      check("rst_lines", 32'({ps2c, ps2d}), 32'd3);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Nominal frame and parity cases.
      run_frame("f4", 8'hF4, 1'b0, -1);
      run_frame("p00", 8'h00, 1'b1, -1);
      run_frame("pff", 8'hFF, 1'b1, -1);
      run_frame("p01", 8'h01, 1'b0, -1);

      // No ACK on both attempts.
      d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
      do_send(8'h3C);
      dev_frame(11, 1'b0, -1, smp, ok);
      check("nak1_dev_ok", 32'(ok), 32'd1);
      dev_frame(11, 1'b0, -1, smp, ok);
      check("nak2_dev_ok", 32'(ok), 32'd1);
      wait_idle("nak", 300);
      check("nak_phases", 32'(inh_phases - p0), 32'd2);
      check("nak_err", 32'(err_cnt - e0), 32'd1);
      check("nak_done", 32'(done_cnt - d0), 32'd0);
      check("nak_code", 32'(err_code), 32'd2);

      // Timeout: device never clocks; a send while busy must be ignored.
      d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
      do_send(8'h12);
      n = 0;
      while (status !== 4'd2 && n < 300) begin @(negedge clk); n++; end
      check("to_req", 32'(status), 32'd2);
      data = 8'hAA;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      check("to_send_ignored", 32'(status), 32'd2);
      wait_idle("to", 1500);
      check("to_phases", 32'(inh_phases - p0), 32'd2);
      check("to_err", 32'(err_cnt - e0), 32'd1);
      check("to_done", 32'(done_cnt - d0), 32'd0);
      check("to_code", 32'(err_code), 32'd1);
      check("to_req_len", 32'(last_req), 32'd200);
      check("to_inh_len", 32'(last_inh), 32'd100);

      // A 1-cycle clock glitch during SHIFT must not advance the bit index.
      run_frame("glitch", 8'h55, 1'b1, 4);

      // Reset in the middle of SHIFT, then a clean frame.
      do_send(8'hA5);
      dev_frame(5, 1'b0, -1, smp, ok);
      check("mid_dev_ok", 32'(ok), 32'd1);
      check("mid_shift", 32'(status), 32'd3);
      check("mid_d_low", 32'(ps2d), 32'd0);
      d0 = done_cnt; e0 = err_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_status", 32'(status), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_lines", 32'({ps2c, ps2d}), 32'd3);
      check("mr_code", 32'(err_code), 32'd0);
      repeat (3) @(negedge clk);
      check("mr_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      run_frame("after_rst", 8'h01, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
